frv_mem_responder: RTL and testbench

FRV_MEM_RESPONDER -- requirements
Module: frv_mem_responder

---
 rtl/frv_mem_responder_pkg.sv | 19 +
 rtl/frv_mem_resp_fifo.sv | 77 +++++++
 rtl/frv_mem_responder.sv | 149 ++++++++++++++
 tb/tb_frv_mem_responder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/frv_mem_responder_pkg.sv
// Shared types and constants for the FRV memory responder.
// Holds the request entry layout and the stall LFSR definition.
package frv_mem_responder_pkg;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] DEF_SEED  = 16'hACE1;

    typedef struct packed {
        logic [31:0] addr;
        logic        wen;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } req_ent_t;

    function automatic logic lfsr_fb(input logic [15:0] s);
        return ^(s & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/frv_mem_resp_fifo.sv
// Per-channel request FIFO; each slot carries an age counter
// that saturates at LAT and marks the head ready to respond.
module frv_mem_resp_fifo
    import frv_mem_responder_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LAT   = 1
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     push,
    input  req_ent_t push_ent,
    input  logic     pop,
    output logic     full,
    output logic     ready,
    output req_ent_t head
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [3:0] LAT4 = 4'(LAT);
    localparam logic [PW:0] DEPTHC = (PW+1)'(DEPTH);

    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PW:0]   cnt_q, cnt_d;
    req_ent_t      mem_q [DEPTH];
    req_ent_t      mem_d [DEPTH];
    logic [3:0]    age_q [DEPTH];
    logic [3:0]    age_d [DEPTH];
    logic          do_push, do_pop;

    always_comb begin
        full    = (cnt_q == DEPTHC);
        head    = mem_q[rptr_q];
        ready   = (cnt_q != '0) && (age_q[rptr_q] == LAT4);
        do_push = push && !full;
        do_pop  = pop && ready;
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < DEPTH; i++) begin
            age_d[i] = (age_q[i] < LAT4) ? age_q[i] + 4'd1 : age_q[i];
        end
        if (do_push) begin
            mem_d[wptr_q] = push_ent;
            age_d[wptr_q] = 4'd0;
            wptr_d        = wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
                age_q[i] <= '0;
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            mem_q  <= mem_d;
            age_q  <= age_d;
        end
    end

endmodule

// File: rtl/frv_mem_responder.sv
// Multi-channel memory responder model with random grant stalls,
// fixed response latency and a flop-array backing store.
module frv_mem_responder
    import frv_mem_responder_pkg::*;
#(
    parameter int          NCH       = 2,
    parameter int          XLEN      = 32,
    parameter int          DEPTH     = 4,
    parameter int          LAT       = 1,
    parameter int          MAX_STALL = 3,
    parameter int          MEM_WORDS = 64,
    parameter logic [31:0] ERR_BASE  = 32'hFFFF_F000,
    parameter logic [31:0] ERR_LIMIT = 32'hFFFF_FFFF,
    parameter logic [15:0] SEED      = DEF_SEED
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall_en,
    input  logic [NCH-1:0]    mem_req,
    input  logic [NCH-1:0]    mem_wen,
    input  logic [NCH*4-1:0]  mem_strb,
    input  logic [NCH*XLEN-1:0] mem_addr,
    input  logic [NCH*XLEN-1:0] mem_wdata,
    output logic [NCH-1:0]    mem_gnt,
    output logic [NCH-1:0]    mem_recv,
    input  logic [NCH-1:0]    mem_ack,
    output logic [NCH-1:0]    mem_error,
    output logic [NCH*XLEN-1:0] mem_rdata
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [7:0] MS8 = 8'(MAX_STALL);

    logic [15:0]     lfsr_q, lfsr_d;
    logic [7:0]      stall_q [NCH];
    logic [7:0]      stall_d [NCH];
    logic [XLEN-1:0] store_q [MEM_WORDS];
    logic [XLEN-1:0] store_d [MEM_WORDS];
    logic [XLEN-1:0] hold_q  [NCH];
    logic [XLEN-1:0] hold_d  [NCH];
    logic [NCH-1:0]  hold_vld_q, hold_vld_d;

    logic [NCH-1:0]  full, ready, push, pop, err;
    req_ent_t        push_ent [NCH];
    req_ent_t        head     [NCH];
    logic [AW-1:0]   idx      [NCH];

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        frv_mem_resp_fifo #(
            .DEPTH (DEPTH),
            .LAT   (LAT)
        ) u_fifo (
            .clock    (clock),
            .reset    (reset),
            .push     (push[c]),
            .push_ent (push_ent[c]),
            .pop      (pop[c]),
            .full     (full[c]),
            .ready    (ready[c]),
            .head     (head[c])
        );
    end

    always_comb begin
        lfsr_d     = {lfsr_q[14:0], lfsr_fb(lfsr_q)};
        store_d    = store_q;
        mem_gnt    = '0;
        mem_recv   = '0;
        mem_error  = '0;
        mem_rdata  = '0;
        push       = '0;
        pop        = '0;
        err        = '0;
        hold_vld_d = hold_vld_q;
        for (int c = 0; c < NCH; c++) begin
            push_ent[c].addr  = 32'(mem_addr[c*XLEN +: XLEN]);
            push_ent[c].wen   = mem_wen[c];
            push_ent[c].strb  = mem_strb[c*4 +: 4];
            push_ent[c].wdata = 32'(mem_wdata[c*XLEN +: XLEN]);

            idx[c] = head[c].addr[AW+1:2];
            err[c] = (head[c].addr >= ERR_BASE) &&
                     (head[c].addr <= ERR_LIMIT);

            mem_gnt[c] = !reset && mem_req[c] && !full[c] &&
                         (!lfsr_q[c] || !stall_en ||
                          stall_q[c] == MS8);
            push[c] = mem_gnt[c];

            if (!mem_req[c] || mem_gnt[c]) begin
                stall_d[c] = '0;
            end else if (!full[c] && stall_q[c] < MS8) begin
                stall_d[c] = stall_q[c] + 8'd1;
            end else begin
                stall_d[c] = stall_q[c];
            end

            mem_recv[c]  = ready[c];
            mem_error[c] = ready[c] && err[c];
            pop[c]       = ready[c] && mem_ack[c];

            // Read data is captured on the first recv cycle so later
            // writes from other channels cannot disturb it.
            hold_d[c] = hold_q[c];
            if (ready[c] && !hold_vld_q[c]) begin
                hold_d[c] = store_q[idx[c]];
            end
            if (pop[c]) begin
                hold_vld_d[c] = 1'b0;
            end else if (ready[c]) begin
                hold_vld_d[c] = 1'b1;
            end
            if (ready[c] && !err[c] && !head[c].wen) begin
                mem_rdata[c*XLEN +: XLEN] = hold_vld_q[c] ?
                    hold_q[c] : store_q[idx[c]];
            end

            if (pop[c] && head[c].wen && !err[c]) begin
                for (int b = 0; b < 4; b++) begin
                    if (head[c].strb[b]) begin
                        store_d[idx[c]][8*b +: 8] =
                            XLEN'(head[c].wdata[8*b +: 8]);
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr_q     <= SEED;
            hold_vld_q <= '0;
            for (int c = 0; c < NCH; c++) begin
                stall_q[c] <= '0;
                hold_q[c]  <= '0;
            end
            for (int w = 0; w < MEM_WORDS; w++) begin
                store_q[w] <= '0;
            end
        end else begin
            lfsr_q     <= lfsr_d;
            hold_vld_q <= hold_vld_d;
            stall_q    <= stall_d;
            hold_q     <= hold_d;
            store_q    <= store_d;
        end
    end

endmodule

// File: tb/tb_frv_mem_responder.sv
// Directed self-checking bench for frv_mem_responder.
module tb_frv_mem_responder;
    import frv_mem_responder_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_en;
    logic [1:0]  req, wen, gnt, recv, ack, error;
    logic [7:0]  strb;
    logic [63:0] addr, wdata, rdata;

    int passed = 0;
    int total  = 0;
    int run;
    int refused;
    logic [31:0] drain_exp [4];

    always #5 clk = ~clk;

    frv_mem_responder dut (
        .clock     (clk),
        .reset     (rst),
        .stall_en  (stall_en),
        .mem_req   (req),
        .mem_wen   (wen),
        .mem_strb  (strb),
        .mem_addr  (addr),
        .mem_wdata (wdata),
        .mem_gnt   (gnt),
        .mem_recv  (recv),
        .mem_ack   (ack),
        .mem_error (error),
        .mem_rdata (rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input int ch, input logic w,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        req[ch]          = 1'b1;
        wen[ch]          = w;
        addr[ch*32 +: 32]  = a;
        wdata[ch*32 +: 32] = d;
        strb[ch*4 +: 4]    = s;
    endtask

    task automatic xact(input string tag, input int ch, input logic w,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic e_err,
                        input logic [31:0] e_rd);
        @(negedge clk);
        drive(ch, w, a, d, s);
        #1 chk({tag, "_gnt"}, 32'(gnt[ch]), 32'd1);
        @(negedge clk);
        req[ch] = 1'b0;
        chk({tag, "_recv_early"}, 32'(recv[ch]), 32'd0);
        @(negedge clk);
        chk({tag, "_recv"}, 32'(recv[ch]), 32'd1);
        chk({tag, "_err"}, 32'(error[ch]), 32'(e_err));
        chk({tag, "_rdata"}, rdata[ch*32 +: 32], e_rd);
        ack[ch] = 1'b1;
        @(negedge clk);
        ack[ch] = 1'b0;
        chk({tag, "_popped"}, 32'(recv[ch]), 32'd0);
    endtask

    task automatic dual(input string tag,
                        input logic w0, input logic [31:0] d0,
                        input logic [3:0] s0, input logic [31:0] e0,
                        input logic w1, input logic [31:0] d1,
                        input logic [3:0] s1, input logic [31:0] a);
        @(negedge clk);
        drive(0, w0, a, d0, s0);
        drive(1, w1, a, d1, s1);
        #1 chk({tag, "_gnt"}, 32'(gnt), 32'd3);
        @(negedge clk);
        req = '0;
        @(negedge clk);
        chk({tag, "_recv"}, 32'(recv), 32'd3);
        chk({tag, "_rd0"}, rdata[31:0], e0);
        ack = 2'b11;
        @(negedge clk);
        ack = '0;
    endtask

    initial begin
        rst = 1'b1; stall_en = 1'b0;
        req = '0; wen = '0; ack = '0; strb = '0;
        addr = '0; wdata = '0;
        req[0] = 1'b1;
        #12;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_recv", 32'(recv), 32'd0);
        chk("rst_err", 32'(error), 32'd0);
        chk("rst_rdata", rdata[31:0], 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req = '0;

        xact("wr10", 0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
        xact("rd10", 0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 32'hDEADBEEF);
        xact("rderr", 0, 1'b0, 32'hFFFF_F004, 32'h0, 4'hF, 1'b1, 32'h0);
        xact("wrerr", 0, 1'b1, 32'hFFFF_F010, 32'h0, 4'hF, 1'b1, 32'h0);
        xact("rd10b", 0, 1'b0, 32'h13, 32'h0, 4'hF, 1'b0, 32'hDEADBEEF);

        xact("wr40", 0, 1'b1, 32'h40, 32'h1, 4'hF, 1'b0, 32'h0);
        xact("wr44", 0, 1'b1, 32'h44, 32'h2, 4'hF, 1'b0, 32'h0);
        xact("wr48", 0, 1'b1, 32'h48, 32'h3, 4'hF, 1'b0, 32'h0);
        xact("wr4c", 0, 1'b1, 32'h4C, 32'h4, 4'hF, 1'b0, 32'h0);

        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            drive(1, 1'b0, 32'h40 + 32'(4*i), 32'h0, 4'hF);
            #1 chk("burst_gnt", 32'(gnt[1]), 32'd1);
            @(negedge clk);
        end
        drive(1, 1'b0, 32'h40, 32'h0, 4'hF);
        #1 chk("full_gnt0", 32'(gnt[1]), 32'd0);
        @(negedge clk);
        chk("full_gnt1", 32'(gnt[1]), 32'd0);
        chk("full_recv", 32'(recv[1]), 32'd1);
        chk("full_rd", rdata[63:32], 32'h1);
        ack[1] = 1'b1;
        #1 chk("full_pop_gnt", 32'(gnt[1]), 32'd0);
        @(negedge clk);
        ack[1] = 1'b0;
        #1 chk("after_pop_gnt", 32'(gnt[1]), 32'd1);
        chk("next_head_recv", 32'(recv[1]), 32'd1);
        @(negedge clk);
        req[1] = 1'b0;
        drain_exp = '{32'h2, 32'h3, 32'h4, 32'h1};
        for (int j = 0; j < 4; j++) begin
            chk("drain_recv", 32'(recv[1]), 32'd1);
            chk("drain_rd", rdata[63:32], drain_exp[j]);
            ack[1] = 1'b1;
            @(negedge clk);
            ack[1] = 1'b0;
        end
        chk("drain_empty", 32'(recv[1]), 32'd0);

        dual("ww20", 1'b1, 32'h11111111, 4'hF, 32'h0,
             1'b1, 32'h22222222, 4'h3, 32'h20);
        xact("rd20", 0, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, 32'h11112222);
        dual("rw20", 1'b0, 32'h0, 4'hF, 32'h11112222,
             1'b1, 32'h33333333, 4'hF, 32'h20);
        xact("rd20b", 0, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, 32'h33333333);

        @(negedge clk);
        stall_en = 1'b1;
        ack[0] = 1'b1;
        drive(0, 1'b0, 32'h10, 32'h0, 4'hF);
        run = 0;
        refused = 0;
        for (int k = 0; k < 100; k++) begin
            #1;
            if (gnt[0]) begin
                run = 0;
            end else begin
                run++;
                refused++;
            end
            chk("stall_run", 32'(run <= 3), 32'd1);
            @(negedge clk);
        end
        chk("stall_seen", 32'(refused > 0), 32'd1);
        req = '0;
        stall_en = 1'b0;
        repeat (4) @(negedge clk);
        ack = '0;
        chk("stall_drained", 32'(recv), 32'd0);

        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1'b0, 32'h10, 32'h0, 4'hF);
            #1 chk("pre_rst_gnt", 32'(gnt[0]), 32'd1);
            @(negedge clk);
        end
        req = '0;
        chk("pre_rst_recv", 32'(recv[0]), 32'd1);
        #2 rst = 1'b1;
        #1 chk("async_recv", 32'(recv), 32'd0);
        chk("async_rdata", rdata[31:0], 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_recv", 32'(recv), 32'd0);
        end
        xact("rd_cleared", 0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
